// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory slave for the CPU MEM-stage port.
// Word array with byte/half/word stores and signed/unsigned loads. Every
// access holds BUSYWAIT for MEM_LATENCY+1 cycles, commits on the last
// ACCESS edge, and shows load data from the DONE cycle onward.
// Optional build macro: DMEM_MISALIGN_ERR_EN adds a MISALIGN output; with it
// misaligned accesses are flagged for the DONE cycle, writes are dropped and
// reads return zero. Without it, misaligned accesses are forced aligned.
// The word array has no reset; its contents survive RESET.
module data_mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  MEM_READ,
  input  logic [2:0]  MEM_WRITE,
  input  logic [31:0] MEM_ADDR,
  input  logic [31:0] MEM_WRITE_DATA,
  output logic [31:0] MEM_READ_DATA,
  output logic        BUSYWAIT
`ifdef DMEM_MISALIGN_ERR_EN
  ,
  output logic        MISALIGN
`endif
);

  localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;

  logic                   req_s;
  logic                   wr_en_s;
  logic                   rd_en_s;
  logic                   last_s;
  logic                   commit_s;
  logic                   busy_s;
  logic                   bad_s;
  logic [ADDR_BITS-1:0]   word_idx_s;
  logic [1:0]             lane_s;
  logic [31:0]            rd_word_s;
  logic [31:0]            rdata_r;
  logic                   unused_addr_s;

  logic [31:0]            mem_r [0:DEPTH-1];

  // Merge store data into the old word on the lanes selected by size/lane.
  // Halves use lane {lane[1],0}; words (and size 11) use all four lanes.
  function automatic logic [31:0] merge_store(
    input logic [31:0] old_w,
    input logic [31:0] wdata,
    input logic [1:0]  size,
    input logic [1:0]  lane
  );
    logic [3:0]  be;
    logic [31:0] rep;
    logic [31:0] mask;
    case (size)
      2'b00: begin
        be  = 4'b0001 << lane;
        rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be  = lane[1] ? 4'b1100 : 4'b0011;
        rep = {2{wdata[15:0]}};
      end
      default: begin
        be  = 4'b1111;
        rep = wdata;
      end
    endcase
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_w & ~mask) | (rep & mask);
  endfunction

  // Select and extend the loaded lane(s) according to funct3.
  function automatic logic [31:0] load_extend(
    input logic [31:0] word,
    input logic [2:0]  funct3,
    input logic [1:0]  lane
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h000000, b};
      3'b101:  return {16'h0000, h};
      default: return word;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_ERR_EN
  // True when the lane is illegal for the access size (kind: 00 byte,
  // 01 half, else word).
  function automatic logic addr_misaligned(
    input logic [1:0] kind,
    input logic [1:0] lane
  );
    case (kind)
      2'b00:   return 1'b0;
      2'b01:   return lane[0];
      default: return (lane != 2'b00);
    endcase
  endfunction
`endif

  assign req_s         = MEM_READ[3] | MEM_WRITE[2];
  assign wr_en_s       = MEM_WRITE[2];
  assign rd_en_s       = MEM_READ[3] & ~MEM_WRITE[2];
  assign word_idx_s    = MEM_ADDR[ADDR_BITS+1:2];
  assign lane_s        = MEM_ADDR[1:0];
  assign rd_word_s     = mem_r[word_idx_s];
  assign last_s        = (cnt_r == CNT_W'(MEM_LATENCY - 1));
  assign unused_addr_s = ^MEM_ADDR[31:ADDR_BITS+2];

`ifdef DMEM_MISALIGN_ERR_EN
  assign bad_s = addr_misaligned(wr_en_s ? MEM_WRITE[1:0] : MEM_READ[1:0], lane_s);
`else
  assign bad_s = 1'b0;
`endif

  // State and latency counter register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_W'(0);
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: accept, count latency, abort on dropped request.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          state_nxt_s = ST_ACCESS;
          cnt_nxt_s   = CNT_W'(0);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!req_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_W'(0);
        end else if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_DONE: begin
        // A request still held here is not restarted until IDLE.
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_W'(0);
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_W'(0);
      end
    endcase
  end

  // Output decode: pipeline hold and the single commit strobe.
  always_comb begin
    busy_s   = req_s && (state_r != ST_DONE);
    commit_s = 1'b0;
    if ((state_r == ST_ACCESS) && req_s && last_s) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  assign BUSYWAIT = busy_s;

  // Array write on commit; a reset on the commit edge discards the store.
  always_ff @(posedge CLK) begin
    if (RESET && commit_s && wr_en_s && !bad_s) begin
      mem_r[word_idx_s] <= merge_store(rd_word_s, MEM_WRITE_DATA, MEM_WRITE[1:0], lane_s);
    end
  end

  // Load result register: updated only by a committed read, else held.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rdata_r <= 32'h0000_0000;
    end else if (commit_s && rd_en_s) begin
      rdata_r <= bad_s ? 32'h0000_0000 : load_extend(rd_word_s, MEM_READ[2:0], lane_s);
    end
  end

  assign MEM_READ_DATA = rdata_r;

`ifdef DMEM_MISALIGN_ERR_EN
  logic misalign_r;

  // Misalign flag: set on the commit edge, so it is high for DONE only.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= commit_s && bad_s;
    end
  end

  assign MISALIGN = misalign_r;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed accesses push their
// expected outcome into a scoreboard; a monitor pops and compares whenever
// the DUT signals completion (request present and BUSYWAIT low).
module tb_data_mem_responder;

  localparam int AB  = 8;
  localparam int LAT = 4;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;
  localparam logic [1:0] S_B   = 2'b00;
  localparam logic [1:0] S_H   = 2'b01;
  localparam logic [1:0] S_W   = 2'b10;

  logic        CLK;
  logic        RESET;
  logic [3:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WRITE_DATA;
  logic [31:0] MEM_READ_DATA;
  logic        BUSYWAIT;
`ifdef DMEM_MISALIGN_ERR_EN
  logic        MISALIGN;
`endif

  data_mem_responder #(.ADDR_BITS(AB), .MEM_LATENCY(LAT)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .MEM_READ       (MEM_READ),
    .MEM_WRITE      (MEM_WRITE),
    .MEM_ADDR       (MEM_ADDR),
    .MEM_WRITE_DATA (MEM_WRITE_DATA),
    .MEM_READ_DATA  (MEM_READ_DATA),
    .BUSYWAIT       (BUSYWAIT)
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    .MISALIGN       (MISALIGN)
`endif
  );

  typedef struct {
    string       name;
    logic        chk;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: on each falling edge, count busy cycles and score completions.
  initial begin : monitor
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge CLK);
      if (!(MEM_READ[3] | MEM_WRITE[2])) begin
        busy_cnt = 0;
      end else if (BUSYWAIT) begin
        busy_cnt++;
      end else begin
        if (sb_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_done: got completion expected none");
        end else begin
          e = sb_q.pop_front();
          check32({e.name, "_busy"}, 32'(busy_cnt), 32'(LAT + 1));
          if (e.chk) check32({e.name, "_data"}, MEM_READ_DATA, e.data);
`ifdef DMEM_MISALIGN_ERR_EN
          check32({e.name, "_mis"}, {31'h0, MISALIGN}, {31'h0, e.mis});
`endif
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic idle_inputs();
    MEM_READ       = 4'h0;
    MEM_WRITE      = 3'h0;
    MEM_ADDR       = 32'h0;
    MEM_WRITE_DATA = 32'h0;
  endtask

  // One full access starting at posedge+1; returns at posedge+1 after DONE.
  task automatic access(input logic rd, input logic [2:0] f3, input logic wr,
                        input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input string nm, input logic chk,
                        input logic [31:0] exp_d, input logic exp_mis);
    exp_t e;
    bit   done;
    e.name = nm; e.chk = chk; e.data = exp_d; e.mis = exp_mis;
    sb_q.push_back(e);
    MEM_READ       = {rd, f3};
    MEM_WRITE      = {wr, sz};
    MEM_ADDR       = addr;
    MEM_WRITE_DATA = wd;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (!BUSYWAIT) done = 1'b1;
    end
    if (!done) begin
      total_cnt++;
      $display("FAIL %s_timeout: got BUSYWAIT stuck high expected release", nm);
    end
    @(posedge CLK); #1;
    idle_inputs();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin : stim
    RESET = 1'b0;
    idle_inputs();
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    @(negedge CLK);
    check32("rst_rdata", MEM_READ_DATA, 32'h0);
    check32("rst_busy", {31'h0, BUSYWAIT}, 32'h0);
    @(posedge CLK); #1;

    // Known contents for words used below.
    access(1'b0, F_LW, 1'b1, S_W, 32'h04, 32'h0, "clr04", 1'b0, 32'h0, 1'b0);
    access(1'b0, F_LW, 1'b1, S_W, 32'h20, 32'h0, "clr20", 1'b0, 32'h0, 1'b0);

    // Word store / load.
    access(1'b0, F_LW, 1'b1, S_W, 32'h10, 32'hDEADBEEF, "sw10", 1'b0, 32'h0, 1'b0);
    access(1'b1, F_LW, 1'b0, S_W, 32'h10, 32'h0, "lw10", 1'b1, 32'hDEADBEEF, 1'b0);

    // Byte store into lane 3 and loads.
    access(1'b0, F_LW, 1'b1, S_W, 32'h10, 32'h11223344, "sw10b", 1'b0, 32'h0, 1'b0);
    access(1'b0, F_LW, 1'b1, S_B, 32'h13, 32'h00000080, "sb13", 1'b0, 32'h0, 1'b0);
    access(1'b1, F_LB,  1'b0, S_W, 32'h13, 32'h0, "lb13",  1'b1, 32'hFFFFFF80, 1'b0);
    access(1'b1, F_LBU, 1'b0, S_W, 32'h13, 32'h0, "lbu13", 1'b1, 32'h00000080, 1'b0);
    access(1'b1, F_LW,  1'b0, S_W, 32'h10, 32'h0, "lw10c", 1'b1, 32'h80223344, 1'b0);

    // Half store into upper half and loads.
    access(1'b0, F_LW, 1'b1, S_H, 32'h22, 32'h0000BEEF, "sh22", 1'b0, 32'h0, 1'b0);
    access(1'b1, F_LH,  1'b0, S_W, 32'h22, 32'h0, "lh22",  1'b1, 32'hFFFFBEEF, 1'b0);
    access(1'b1, F_LHU, 1'b0, S_W, 32'h22, 32'h0, "lhu22", 1'b1, 32'h0000BEEF, 1'b0);
    access(1'b1, F_LW,  1'b0, S_W, 32'h20, 32'h0, "lw20",  1'b1, 32'hBEEF0000, 1'b0);

    // Abort: drop the store request while cnt==1.
    MEM_WRITE = {1'b1, S_W}; MEM_ADDR = 32'h04; MEM_WRITE_DATA = 32'h55;
    repeat (2) @(posedge CLK);
    #1 idle_inputs();
    @(posedge CLK); #1;
    access(1'b1, F_LW, 1'b0, S_W, 32'h04, 32'h0, "lw04_abort", 1'b1, 32'h0, 1'b0);

    // Reset in ACCESS with a nonzero load result held beforehand.
    access(1'b1, F_LW, 1'b0, S_W, 32'h10, 32'h0, "lw10_pre", 1'b1, 32'h80223344, 1'b0);
    MEM_WRITE = {1'b1, S_W}; MEM_ADDR = 32'h04; MEM_WRITE_DATA = 32'h55;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    repeat (4) @(posedge CLK);
    #1 RESET = 1'b1;
    idle_inputs();
    @(negedge CLK);
    check32("midrst_busy", {31'h0, BUSYWAIT}, 32'h0);
    check32("midrst_rdata", MEM_READ_DATA, 32'h0);
    @(posedge CLK); #1;
    access(1'b1, F_LW, 1'b0, S_W, 32'h04, 32'h0, "lw04_rst", 1'b1, 32'h0, 1'b0);

    // Address wrap modulo 256 words.
    access(1'b0, F_LW, 1'b1, S_W, 32'h400, 32'hA5A5A5A5, "sw400", 1'b0, 32'h0, 1'b0);
    access(1'b1, F_LW, 1'b0, S_W, 32'h000, 32'h0, "lw000", 1'b1, 32'hA5A5A5A5, 1'b0);

    // Read and write together: write commits, load result unchanged.
    access(1'b1, F_LW, 1'b0, S_W, 32'h20, 32'h0, "lw20b", 1'b1, 32'hBEEF0000, 1'b0);
    access(1'b1, F_LW, 1'b1, S_W, 32'h20, 32'h12345678, "rw_prio", 1'b1, 32'hBEEF0000, 1'b0);
    access(1'b1, F_LW, 1'b0, S_W, 32'h20, 32'h0, "lw20c", 1'b1, 32'h12345678, 1'b0);

    // Size 11 stores a full word; unlisted funct3 returns the full word.
    access(1'b0, F_LW, 1'b1, 2'b11, 32'h30, 32'hCAFEF00D, "sz11", 1'b0, 32'h0, 1'b0);
    access(1'b1, 3'b011, 1'b0, S_W, 32'h30, 32'h0, "f3_011", 1'b1, 32'hCAFEF00D, 1'b0);

`ifdef DMEM_MISALIGN_ERR_EN
    access(1'b1, F_LW, 1'b0, S_W, 32'h01, 32'h0, "lw01_mis", 1'b1, 32'h0, 1'b1);
    access(1'b1, F_LH, 1'b0, S_W, 32'h23, 32'h0, "lh23_mis", 1'b1, 32'h0, 1'b1);
    access(1'b0, F_LW, 1'b1, S_W, 32'h32, 32'h0, "sw32_mis", 1'b0, 32'h0, 1'b1);
    access(1'b1, F_LW, 1'b0, S_W, 32'h30, 32'h0, "lw30_keep", 1'b1, 32'hCAFEF00D, 1'b0);
`else
    access(1'b1, F_LW, 1'b0, S_W, 32'h01, 32'h0, "lw01_align", 1'b1, 32'hA5A5A5A5, 1'b0);
    access(1'b1, F_LH, 1'b0, S_W, 32'h23, 32'h0, "lh23_align", 1'b1, 32'h00001234, 1'b0);
    access(1'b0, F_LW, 1'b1, S_W, 32'h32, 32'h0BADF00D, "sw32_align", 1'b0, 32'h0, 1'b0);
    access(1'b1, F_LW, 1'b0, S_W, 32'h30, 32'h0, "lw30_new", 1'b1, 32'h0BADF00D, 1'b0);
`endif

    repeat (3) @(posedge CLK);
    check32("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
